// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types used by the caches, the RAM model and the memory arbiter.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // RAM handshake state as seen by the arbiter.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter FSM: IDLE picks an owner, GRANT holds it until completion or abort.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first set bit of req at or above ptr, wrapping at N.
module rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest active requester wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr) + i) % N);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between the data and instruction caches of CPUS cores.
// Requester r = 2*c is core c's data cache, r = 2*c+1 its instruction cache.
// State table:
//   IDLE  | no owner; RAM enables low; pick next owner round-robin from rr_ptr
//   GRANT | owner drives RAM; wait released on ACCESS/ERROR, dropped request aborts
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CPUS-1:0] iREN,
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  word_t           iaddr  [CPUS],
    input  word_t           daddr  [CPUS],
    input  word_t           dstore [CPUS],
    input  ramstate_t       ramstate,
    input  word_t           ramload,
    output logic [CPUS-1:0] iwait,
    output logic [CPUS-1:0] dwait,
    output word_t           iload  [CPUS],
    output word_t           dload  [CPUS],
    output word_t           ramaddr,
    output word_t           ramstore,
    output logic            ramREN,
    output logic            ramWEN
);

    localparam int NREQ = 2 * CPUS;
    localparam int IW   = $clog2(NREQ);
    localparam int CW   = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t    state, state_next;
    logic [IW-1:0] owner, owner_next;
    logic [IW-1:0] rr_ptr, rr_next;
    logic [NREQ-1:0] req;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic [CW-1:0] own_core;
    logic          own_instr;
    logic          own_req;

    for (genvar c = 0; c < CPUS; c++) begin : g_core
        assign req[2*c]   = dREN[c] | dWEN[c];
        assign req[2*c+1] = iREN[c];
        assign iload[c]   = ramload;
        assign dload[c]   = ramload;
    end

    assign own_core  = CW'(owner >> 1);
    assign own_instr = owner[0];
    assign own_req   = req[owner];

    rr_picker #(.N(NREQ)) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // State, owner and round-robin pointer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_next;
        end
    end

    // Next-state decision and combinational RAM/wait outputs for the current owner.
    always_comb begin
        state_next = state;
        owner_next = owner;
        rr_next    = rr_ptr;
        iwait      = '1;
        dwait      = '1;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_next = pick_idx;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    // Owner gave up: drop the transfer and keep its priority.
                    state_next = IDLE;
                end else begin
                    if (own_instr) begin
                        ramaddr = iaddr[own_core];
                        ramREN  = 1'b1;
                    end else begin
                        ramaddr = daddr[own_core];
                        if (dWEN[own_core]) begin
                            ramWEN   = 1'b1;
                            ramstore = dstore[own_core];
                        end else begin
                            ramREN = 1'b1;
                        end
                    end
                    // ERROR completes the transfer too; there is no retry.
                    if (ramstate == ACCESS || ramstate == ERROR) begin
                        if (own_instr) iwait[own_core] = 1'b0;
                        else           dwait[own_core] = 1'b0;
                        state_next = IDLE;
                        rr_next    = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
